lib_onehot_idx_ser: RTL and testbench



---
 rtl/lib_onehot_idx_ser.sv | 117 +++++++++++
 tb/tb_lib_onehot_idx_ser.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lib_onehot_idx_ser.sv
// Serialises the set bits of a one-hot-per-position vector into a stream of
// binary indices, lowest-first or highest-first, with a done/count/overflow summary.
module lib_onehot_idx_ser #(
  parameter int WIDTH   = 16,
  parameter int MAX_NUM = WIDTH,
  parameter int LSB_MSB = 0,
  localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int CNT_W  = $clog2(MAX_NUM + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vect_vld_i,
  output logic             vect_rdy_o,
  input  logic [WIDTH-1:0] vect_i,
  output logic             idx_vld_o,
  input  logic             idx_rdy_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             idx_last_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] rem_q;
  logic [CNT_W-1:0] emit_cnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  logic [IDX_W-1:0] first_idx;
  logic             found;
  logic [WIDTH-1:0] rem_clr;
  logic             rem_one;
  logic             at_max;
  logic             beat_fire;

  // Priority pick of the next set bit in the configured scan order.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    first_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!found && rem_q[(LSB_MSB != 0) ? (WIDTH - 1 - i) : i]) begin
        first_idx = IDX_W'((LSB_MSB != 0) ? (WIDTH - 1 - i) : i);
        found     = 1'b1;
      end
    end
  end

  assign rem_clr   = rem_q & ~(WIDTH'(1) << first_idx);
  assign rem_one   = (rem_q != '0) && ((rem_q & (rem_q - WIDTH'(1))) == '0);
  assign at_max    = (emit_cnt_q == CNT_W'(MAX_NUM - 1));
  assign beat_fire = (state_q == EMIT) && idx_rdy_i;

  // Input side depends only on state and reset, never on idx_rdy_i.
  assign vect_rdy_o = (state_q == IDLE) && !rst;
  assign idx_vld_o  = (state_q == EMIT);
  assign idx_o      = first_idx;
  assign idx_last_o = (state_q == EMIT) && (rem_one || at_max);
  assign done_o     = (state_q == DONE);
  assign cnt_o      = cnt_q;
  assign ovf_o      = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      emit_cnt_q <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state_q)
        IDLE: begin
          if (vect_vld_i) begin
            rem_q      <= vect_i;
            emit_cnt_q <= '0;
            if (vect_i == '0) begin
              state_q <= DONE;
              cnt_q   <= '0;
              ovf_q   <= 1'b0;
            end else begin
              state_q <= EMIT;
            end
          end
        end
        EMIT: begin
          if (beat_fire) begin
            emit_cnt_q <= emit_cnt_q + CNT_W'(1);
            if (idx_last_o) begin
              // Bits left after the final permitted beat are dropped and flagged.
              state_q <= DONE;
              rem_q   <= '0;
              cnt_q   <= emit_cnt_q + CNT_W'(1);
              ovf_q   <= (rem_clr != '0);
            end else begin
              rem_q <= rem_clr;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lib_onehot_idx_ser.sv
// Directed bench: three instances (LSB-first, MSB-first, MAX_NUM=2) share
// stimulus; each vector's beats, last flag, done pulse and summary are checked.
module tb_lib_onehot_idx_ser;

  logic        clk;
  logic        rst;
  logic        vect_vld;
  logic [15:0] vect;
  logic        idx_rdy;

  logic        vect_rdy [3];
  logic        idx_vld  [3];
  logic [3:0]  idx      [3];
  logic        idx_last [3];
  logic        done     [3];
  logic [4:0]  cnt      [3];
  logic        ovf      [3];
  logic [1:0]  cnt_m2;

  int checks = 0;
  int errors = 0;

  int         n_beats   [3];
  logic [3:0] beat_idx  [3][16];
  int         beat_cyc  [3][16];
  int         last_pos  [3];
  int         first_vld [3];
  int         done_cnt  [3];
  int         done_cyc  [3];
  logic [4:0] done_val  [3];
  logic       ovf_val   [3];
  logic       rdy_after [3];

  assign cnt[2] = {3'b000, cnt_m2};

  lib_onehot_idx_ser #(.WIDTH(16), .MAX_NUM(16), .LSB_MSB(0)) u_lsb (
    .clk(clk), .rst(rst), .vect_vld_i(vect_vld), .vect_rdy_o(vect_rdy[0]), .vect_i(vect),
    .idx_vld_o(idx_vld[0]), .idx_rdy_i(idx_rdy), .idx_o(idx[0]), .idx_last_o(idx_last[0]),
    .done_o(done[0]), .cnt_o(cnt[0]), .ovf_o(ovf[0])
  );

  lib_onehot_idx_ser #(.WIDTH(16), .MAX_NUM(16), .LSB_MSB(1)) u_msb (
    .clk(clk), .rst(rst), .vect_vld_i(vect_vld), .vect_rdy_o(vect_rdy[1]), .vect_i(vect),
    .idx_vld_o(idx_vld[1]), .idx_rdy_i(idx_rdy), .idx_o(idx[1]), .idx_last_o(idx_last[1]),
    .done_o(done[1]), .cnt_o(cnt[1]), .ovf_o(ovf[1])
  );

  lib_onehot_idx_ser #(.WIDTH(16), .MAX_NUM(2), .LSB_MSB(0)) u_max2 (
    .clk(clk), .rst(rst), .vect_vld_i(vect_vld), .vect_rdy_o(vect_rdy[2]), .vect_i(vect),
    .idx_vld_o(idx_vld[2]), .idx_rdy_i(idx_rdy), .idx_o(idx[2]), .idx_last_o(idx_last[2]),
    .done_o(done[2]), .cnt_o(cnt_m2), .ovf_o(ovf[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer one vector with idx_rdy held high and record 20 cycles of activity.
  task automatic run_vec(input logic [15:0] v);
    for (int k = 0; k < 3; k++) begin
      n_beats[k]   = 0;
      last_pos[k]  = -1;
      first_vld[k] = -1;
      done_cnt[k]  = 0;
      done_cyc[k]  = -1;
      done_val[k]  = '0;
      ovf_val[k]   = 1'b0;
      rdy_after[k] = 1'b0;
    end
    idx_rdy  = 1'b1;
    vect     = v;
    vect_vld = 1'b1;
    @(posedge clk); #1;
    vect_vld = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (c > 1 && done_cyc[k] == c - 1) rdy_after[k] = vect_rdy[k];
        if (idx_vld[k]) begin
          if (first_vld[k] < 0) first_vld[k] = c;
          if (idx_rdy && n_beats[k] < 16) begin
            beat_idx[k][n_beats[k]] = idx[k];
            beat_cyc[k][n_beats[k]] = c;
            if (idx_last[k]) last_pos[k] = n_beats[k];
            n_beats[k]++;
          end
        end
        if (done[k]) begin
          done_cnt[k]++;
          done_cyc[k] = c;
          done_val[k] = cnt[k];
          ovf_val[k]  = ovf[k];
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // seq holds expected indices as nibbles, first beat in the lowest nibble.
  task automatic expect_run(input string name, input int k, input int n,
                            input logic [63:0] seq, input int exp_cnt, input logic exp_ovf);
    check($sformatf("%s/u%0d/n_beats", name, k), n_beats[k], n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s/u%0d/idx%0d", name, k, i), beat_idx[k][i], seq[4*i +: 4]);
      check($sformatf("%s/u%0d/cyc%0d", name, k, i), beat_cyc[k][i], i + 1);
    end
    if (n == 0) check($sformatf("%s/u%0d/no_vld", name, k), first_vld[k], -1);
    check($sformatf("%s/u%0d/last_pos", name, k), last_pos[k], n - 1);
    check($sformatf("%s/u%0d/done_pulses", name, k), done_cnt[k], 1);
    check($sformatf("%s/u%0d/done_cyc", name, k), done_cyc[k], n + 1);
    check($sformatf("%s/u%0d/cnt", name, k), done_val[k], exp_cnt);
    check($sformatf("%s/u%0d/ovf", name, k), ovf_val[k], exp_ovf);
    check($sformatf("%s/u%0d/rdy_after_done", name, k), rdy_after[k], 1);
  endtask

  initial begin
    rst      = 1'b1;
    vect_vld = 1'b0;
    vect     = '0;
    idx_rdy  = 1'b1;

    #3;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst/u%0d/vect_rdy", k), vect_rdy[k], 0);
      check($sformatf("rst/u%0d/idx_vld", k), idx_vld[k], 0);
      check($sformatf("rst/u%0d/done", k), done[k], 0);
      check($sformatf("rst/u%0d/cnt", k), cnt[k], 0);
      check($sformatf("rst/u%0d/ovf", k), ovf[k], 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("post_rst/u%0d/vect_rdy", k), vect_rdy[k], 1);
    @(posedge clk); #1;

    run_vec(16'h8421);
    expect_run("v8421", 0, 4, 64'hF_A_5_0, 4, 1'b0);
    expect_run("v8421", 1, 4, 64'h0_5_A_F, 4, 1'b0);
    expect_run("v8421", 2, 2, 64'h5_0,     2, 1'b1);

    run_vec(16'h0000);
    for (int k = 0; k < 3; k++) expect_run("v0000", k, 0, 64'h0, 0, 1'b0);

    run_vec(16'h0007);
    expect_run("v0007", 0, 3, 64'h2_1_0, 3, 1'b0);
    expect_run("v0007", 1, 3, 64'h0_1_2, 3, 1'b0);
    expect_run("v0007", 2, 2, 64'h1_0,   2, 1'b1);

    // Exactly MAX_NUM bits set: no overflow on the capped instance.
    run_vec(16'h0003);
    expect_run("v0003", 0, 2, 64'h1_0, 2, 1'b0);
    expect_run("v0003", 1, 2, 64'h0_1, 2, 1'b0);
    expect_run("v0003", 2, 2, 64'h1_0, 2, 1'b0);

    run_vec(16'h0001);
    for (int k = 0; k < 3; k++) expect_run("v0001", k, 1, 64'h0, 1, 1'b0);

    // Back-pressure on the first beat with stray vect_vld pulses during EMIT.
    idx_rdy  = 1'b0;
    vect     = 16'h0104;
    vect_vld = 1'b1;
    @(posedge clk); #1;
    vect_vld = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d/vld", c), idx_vld[0], 1);
      check($sformatf("stall%0d/idx", c), idx[0], 2);
      check($sformatf("stall%0d/last", c), idx_last[0], 0);
      check($sformatf("stall%0d/vect_rdy", c), vect_rdy[0], 0);
      @(posedge clk); #1;
      if (c == 1) begin
        vect_vld = 1'b1;
        vect     = 16'hFFFF;
      end else begin
        vect_vld = 1'b0;
      end
    end
    idx_rdy = 1'b1;
    @(negedge clk);
    check("stall/beat0_idx", idx[0], 2);
    check("stall/beat0_last", idx_last[0], 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall/beat1_idx", idx[0], 8);
    check("stall/beat1_last", idx_last[0], 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall/done", done[0], 1);
    check("stall/cnt", cnt[0], 2);
    check("stall/ovf", ovf[0], 0);
    repeat (4) begin
      @(posedge clk); #1;
    end

    // Reset in the middle of emitting 16'hFFFF.
    idx_rdy  = 1'b1;
    vect     = 16'hFFFF;
    vect_vld = 1'b1;
    @(posedge clk); #1;
    vect_vld = 1'b0;
    @(negedge clk);
    check("rstmid/beat0", idx[0], 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid/beat1", idx[0], 1);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rstmid/u%0d/idx_vld", k), idx_vld[k], 0);
      check($sformatf("rstmid/u%0d/vect_rdy", k), vect_rdy[k], 0);
      check($sformatf("rstmid/u%0d/done", k), done[k], 0);
      check($sformatf("rstmid/u%0d/cnt", k), cnt[k], 0);
      check($sformatf("rstmid/u%0d/ovf", k), ovf[k], 0);
    end
    repeat (2) begin
      @(negedge clk);
      check("rsthold/done", done[0], 0);
      check("rsthold/vect_rdy", vect_rdy[0], 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstrel/vect_rdy", vect_rdy[0], 1);
    check("rstrel/idx_vld", idx_vld[0], 0);
    check("rstrel/done", done[0], 0);
    @(posedge clk); #1;

    run_vec(16'h0010);
    for (int k = 0; k < 3; k++) expect_run("v0010", k, 1, 64'h4, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
